ysyx_22050612_ifu: RTL and testbench

Instruction fetch unit for the multicycle core. It owns the architectural PC and issues one fetch request per instruction to instruction memory. It hands the fetched word and its PC to decode/execute, then waits for the execute stage's next-PC (`dnpc`) before fetching again. It is the producer of the `pc` consumed by execute and the consumer of the `dnpc` that execute returns.

---
 rtl/ysyx_22050612_ifu.sv | 106 ++++++++++
 tb/tb_ysyx_22050612_ifu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction and
// waits for execute to return the next PC before fetching again.
module ysyx_22050612_ifu #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] pc,
    input  logic        dnpc_valid,
    input  logic [63:0] dnpc,
    output logic        fault,
    output logic [63:0] instret
);

    // state | meaning
    // S_REQ   | fetch request presented to memory
    // S_WAIT  | request accepted, waiting for the instruction word
    // S_ISSUE | instruction offered to decode
    // S_EXEC  | waiting for execute to retire and return dnpc
    // S_HALT  | misaligned dnpc seen; idle until reset
    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        fault_q, fault_d;
    logic [63:0] instret_q, instret_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            inst_q    <= NOP;
            fault_q   <= 1'b0;
            instret_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        fault_d   = fault_q;
        instret_d = instret_q;
        case (state_q)
            S_REQ: begin
                if (mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    inst_d  = mem_resp_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (inst_ready) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (dnpc_valid) begin
                    instret_d = instret_q + 64'd1;
                    if (dnpc[1:0] == 2'b00) begin
                        pc_d    = dnpc;
                        state_d = S_REQ;
                    end else begin
                        // the offending dnpc is discarded so pc still names the faulting instruction
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_REQ;
        endcase
    end

    assign mem_req_valid = (state_q == S_REQ);
    assign inst_valid    = (state_q == S_ISSUE);
    assign mem_req_addr  = pc_q;
    assign pc            = pc_q;
    assign inst          = inst_q;
    assign fault         = fault_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Directed bench for the fetch unit: a scoreboard queue holds the expected
// fetch address/word/next-PC of each instruction driven through the DUT.
module tb_ysyx_22050612_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        dnpc_valid = 1'b0;
    logic [63:0] dnpc = 64'h0;
    logic        fault;
    logic [63:0] instret;

    ysyx_22050612_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .dnpc_valid     (dnpc_valid),
        .dnpc           (dnpc),
        .fault          (fault),
        .instret        (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        logic [63:0] npc;
    } fetch_t;

    fetch_t      sb[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    logic [63:0] m_pc;
    logic [63:0] m_instret;
    logic        m_fault;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_pc      = 64'h8000_0000;
        m_instret = 64'd0;
        m_fault   = 1'b0;
    endtask

    // One instruction through REQ/WAIT/ISSUE/EXEC with optional handshake stalls
    // and optional stray dnpc pulses while in REQ and WAIT.
    task automatic run_instr(input logic [31:0] data, input logic [63:0] npc,
                             input int req_stall, input int iss_stall,
                             input bit stray, output int req_cyc);
        fetch_t e;
        sb.push_back('{addr: m_pc, data: data, npc: npc});
        for (int i = 0; i < 50 && !mem_req_valid; i++) tick();
        req_cyc = cyc;
        e = sb.pop_front();
        chk("req_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("req_addr", mem_req_addr, e.addr);
        if (stray) begin
            dnpc_valid = 1'b1; dnpc = 64'h8000_1000;
            tick();
            dnpc_valid = 1'b0;
            chk("stray_req_pc", pc, e.addr);
            chk("stray_req_valid", {63'd0, mem_req_valid}, 64'd1);
        end
        for (int i = 0; i < req_stall; i++) begin
            tick();
            chk("req_hold_valid", {63'd0, mem_req_valid}, 64'd1);
            chk("req_hold_addr", mem_req_addr, e.addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("wait_req_valid", {63'd0, mem_req_valid}, 64'd0);
        if (stray) begin
            dnpc_valid = 1'b1; dnpc = 64'h8000_1000;
            tick();
            dnpc_valid = 1'b0;
            chk("stray_wait_pc", pc, e.addr);
            chk("stray_wait_ivalid", {63'd0, inst_valid}, 64'd0);
        end
        mem_resp_valid = 1'b1; mem_resp_data = e.data;
        tick();
        mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        chk("issue_valid", {63'd0, inst_valid}, 64'd1);
        chk("issue_inst", {32'd0, inst}, {32'd0, e.data});
        chk("issue_pc", pc, e.addr);
        for (int i = 0; i < iss_stall; i++) begin
            tick();
            chk("iss_hold_valid", {63'd0, inst_valid}, 64'd1);
            chk("iss_hold_inst", {32'd0, inst}, {32'd0, e.data});
            chk("iss_hold_pc", pc, e.addr);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("exec_ivalid", {63'd0, inst_valid}, 64'd0);
        dnpc_valid = 1'b1; dnpc = e.npc;
        tick();
        dnpc_valid = 1'b0; dnpc = 64'h0;
        m_instret = m_instret + 64'd1;
        if (e.npc[1:0] == 2'b00) m_pc = e.npc;
        else m_fault = 1'b1;
        chk("post_pc", pc, m_pc);
        chk("post_instret", instret, m_instret);
        chk("post_fault", {63'd0, fault}, {63'd0, m_fault});
    endtask

    initial begin
        int c0, c1, cx;
        do_reset();
        chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("rst_pc", pc, 64'h8000_0000);
        chk("rst_addr", mem_req_addr, 64'h8000_0000);
        chk("rst_inst", {32'd0, inst}, 64'h13);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_fault", {63'd0, fault}, 64'd0);
        chk("rst_instret", instret, 64'd0);

        run_instr(32'h0010_0093, 64'h8000_0004, 0, 0, 0, c0);
        run_instr(32'h0020_0113, 64'h8000_0008, 5, 3, 0, c1);
        chk("loop_cycles", 64'(c1 - c0), 64'd4);

        run_instr(32'h0030_0193, 64'h8000_0100, 0, 0, 1, cx);
        run_instr(32'h0040_0213, 64'h8000_0104, 0, 0, 0, cx);

        // reset while WAIT, then a stale response after release
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("pre_rst_wait", {63'd0, mem_req_valid}, 64'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, 64'h8000_0000);
        tick();
        rst = 1'b0;
        m_pc = 64'h8000_0000; m_instret = 64'd0; m_fault = 1'b0;
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        chk("stale_inst", {32'd0, inst}, 64'h13);
        chk("stale_ivalid", {63'd0, inst_valid}, 64'd0);
        chk("stale_req_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("stale_addr", mem_req_addr, 64'h8000_0000);
        chk("stale_instret", instret, 64'd0);

        // misaligned dnpc
        run_instr(32'h0000_0067, 64'h8000_0006, 0, 0, 0, cx);
        chk("halt_pc", pc, 64'h8000_0000);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req_valid || inst_valid || !fault)
                chk("halt_idle", {61'd0, mem_req_valid, inst_valid, fault}, 64'd1);
        end
        chk("halt_idle_end", {61'd0, mem_req_valid, inst_valid, fault}, 64'd1);
        do_reset();
        chk("clr_fault", {63'd0, fault}, 64'd0);
        chk("clr_req_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("clr_addr", mem_req_addr, 64'h8000_0000);

        // instret wrap using self-loop dnpc
        dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        run_instr(32'h0000_006F, 64'h8000_0000, 0, 0, 0, cx);
        chk("wrap_max", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        run_instr(32'h0000_006F, 64'h8000_0000, 0, 0, 0, cx);
        chk("wrap_zero", instret, 64'd0);
        chk("selfloop_addr", mem_req_addr, 64'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
